dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the CPU's single-port 8-bit data memory between the CPU load/store path and a debug/readout port. Selects one requester per cycle with two-way round-robin and steers the one-cycle-latency read data back to the requester that issued the read. Keeps a saturating count of cycles with a lost contention. Sits between `top_CPU`'s data-memory interface and the data memory instance, so a bench or debug master can read results while the CPU runs.

## Interface

**Parameters**
- `AW`, default 5: word-address width (32 words).
- `DW`, default 8: data width.

**Ports** (each line: name, direction, width, meaning)
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `cpu_req`, in, 1: CPU access request.
- `cpu_we`, in, 1: write when 1, read when 0.
- `cpu_addr`, in, AW: CPU word address.
- `cpu_wdata`, in, DW: CPU write data.
- `cpu_gnt`, out, 1: CPU access performed this cycle.
- `cpu_rdata`, out, DW: CPU read data, qualified by `cpu_rvalid`.
- `cpu_rvalid`, out, 1: CPU read data valid.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rdata`, `dbg_rvalid`: debug port, same widths and meanings as the CPU port.
- `mem_en`, out, 1: memory access strobe.
- `mem_we`, out, 1: memory write enable.
- `mem_addr`, out, AW: memory address.
- `mem_wdata`, out, DW: memory write data.
- `mem_rdata`, in, DW: memory read data, valid one cycle after a read strobe.
- `conflict_cnt`, out, 8: saturating count of cycles where both ports requested.

## Operation

**Arbitration** (combinational from `*_req` and the registered `last_win`)
- Only one port requesting: that port wins.
- Both ports requesting: the port not equal to `last_win` wins.
- Neither requesting: `mem_en`=0, both grants 0.

**Memory port**
- The winner's `we`, `addr` and `wdata` drive the memory port.
- `mem_en`=1 and the winner's `gnt`=1 in the same cycle.

**Pointer**
- `last_win` updates to the winner on every granted cycle.
- `last_win` holds when no port is granted.

**Read response**
- A granted read (`we`=0) sets a one-entry response register `{valid, owner}`.
- Next cycle: the owner's `rvalid`=1; the other port's `rvalid`=0.
- Both `*_rdata` are driven directly from `mem_rdata` and are meaningful only while `rvalid` is high.
- A granted write produces no `rvalid`.

**Conflict counter**
- `conflict_cnt` increments by 1 on every cycle where `cpu_req` and `dbg_req` are both 1.
- Saturates at 255; no wrap.

**Requester rules**
- A requester holds `req`, `we`, `addr` and `wdata` stable until it samples `gnt`=1 at a rising edge.
- `req` may be deasserted or retargeted only after the grant.

## Timing

**Reset values** (while `reset`=0, asynchronously)
- `last_win`=DBG, so the CPU wins the first contention.
- Response register cleared: `cpu_rvalid`=`dbg_rvalid`=0.
- `conflict_cnt`=0.
- `cpu_gnt`=`dbg_gnt`=0 and `mem_en`=0 regardless of the request inputs.

**Latency and throughput**
- Grant latency is 0 cycles: the grant is combinational in the request cycle.
- Read data latency is 1 cycle: `rvalid` in the cycle after the grant.
- Throughput is one access per cycle, with back-to-back grants to the same or alternating ports.

**Boundary conditions**
- Reset asserted the cycle after a granted read: the pending `rvalid` is dropped, never delivered.
- Simultaneous read grant and pending `rvalid` are independent: the pipeline overlaps with no bubble.
- Sustained contention strictly alternates CPU, DBG, CPU, DBG.

## Structure

**Package `dmem_arb_pkg`**
- `typedef enum logic {REQ_CPU, REQ_DBG} requester_t`.
- Defaults `DMEM_AW`=5 and `DMEM_DW`=8.
- `CONFLICT_MAX`=8'd255.

**Sub-module `rr_arb2`**
- Two-input round-robin picker.
- Inputs: two `req` bits and `last_win`.
- Outputs: one-hot grant and winner id.
- Purely combinational; `last_win` is registered in `dmem_arbiter`.

## Test plan

1. **Write then read.** CPU writes 8'd13 to addr 5; the next cycle CPU reads addr 5.
   - Required: `cpu_gnt` on both cycles.
   - Required: `cpu_rvalid`=1 with `cpu_rdata`=13 one cycle after the read; `dbg_rvalid` stays 0.
2. **Debug readout.** Memory holds 1,1,2,3,5 at addrs 0–4; DBG reads addrs 0–4 on consecutive cycles while CPU is idle.
   - Required: `dbg_gnt` every cycle.
   - Required: `dbg_rvalid` on 5 consecutive cycles, delivering 1,1,2,3,5.
3. **Contention.** Both ports read continuously for 4 cycles after reset.
   - Required: grants CPU, DBG, CPU, DBG.
   - Required: each `rvalid` is routed to the correct owner; `conflict_cnt`=4.
4. **Counter saturation.** Both ports request for 300 cycles.
   - Required: `conflict_cnt`=255 and it holds at 255.
5. **Reset during a read.** Assert `reset` low the cycle after a DBG read grant.
   - Required: `dbg_rvalid`=0 and `conflict_cnt`=0.
   - Required: after release, the first contention grants CPU.
6. **Write produces no response.** DBG writes 8'hAA to addr 31.
   - Required: `dbg_gnt`=1 and no `rvalid` on either port.
   - Required: a following CPU read of addr 31 returns 8'hAA.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Requester ids, address/data widths and the conflict counter ceiling.
package dmem_arb_pkg;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } requester_t;

    localparam int          DMEM_AW      = 5;
    localparam int          DMEM_DW      = 8;
    localparam logic [7:0]  CONFLICT_MAX = 8'd255;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin picker: on contention the port that did not win last time goes.
// Purely combinational; the last-winner pointer lives in the parent.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0]  req,       // bit 0 = CPU, bit 1 = DBG
    input  requester_t  last_win,
    output logic [1:0]  gnt,       // one-hot, same bit order as req
    output requester_t  winner
);

    always_comb begin
        gnt    = 2'b00;
        winner = last_win;
        case (req)
            2'b01: begin
                gnt    = 2'b01;
                winner = REQ_CPU;
            end
            2'b10: begin
                gnt    = 2'b10;
                winner = REQ_DBG;
            end
            2'b11: begin
                if (last_win == REQ_DBG) begin
                    gnt    = 2'b01;
                    winner = REQ_CPU;
                end else begin
                    gnt    = 2'b10;
                    winner = REQ_DBG;
                end
            end
            default: begin
                gnt    = 2'b00;
                winner = last_win;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU and a debug port, routing the
// one-cycle read data back to the issuer and counting contended cycles.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW = DMEM_AW,
    parameter int DW = DMEM_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_rvalid,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [7:0]    conflict_cnt
);

    // Handshake: a requester holds req/we/addr/wdata stable until it sees gnt=1 at a
    // rising edge; the access happens in that same cycle and a read answers with
    // rvalid exactly one cycle later. There is no back-pressure on the response.

    requester_t last_win;
    requester_t winner;
    logic [1:0] req_gated;
    logic [1:0] gnt;
    logic       rsp_valid;
    requester_t rsp_owner;

    // Requests are masked while reset is held so nothing reaches memory.
    assign req_gated = {dbg_req, cpu_req} & {2{reset}};

    rr_arb2 u_rr_arb2 (
        .req      (req_gated),
        .last_win (last_win),
        .gnt      (gnt),
        .winner   (winner)
    );

    assign cpu_gnt   = gnt[0];
    assign dbg_gnt   = gnt[1];
    assign mem_en    = |gnt;
    assign mem_we    = (winner == REQ_DBG) ? dbg_we    : cpu_we;
    assign mem_addr  = (winner == REQ_DBG) ? dbg_addr  : cpu_addr;
    assign mem_wdata = (winner == REQ_DBG) ? dbg_wdata : cpu_wdata;

    assign cpu_rdata  = mem_rdata;
    assign dbg_rdata  = mem_rdata;
    assign cpu_rvalid = rsp_valid && (rsp_owner == REQ_CPU);
    assign dbg_rvalid = rsp_valid && (rsp_owner == REQ_DBG);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_win     <= REQ_DBG;
            rsp_valid    <= 1'b0;
            rsp_owner    <= REQ_CPU;
            conflict_cnt <= 8'd0;
        end else begin
            if (mem_en) begin
                last_win <= winner;
            end
            rsp_valid <= mem_en && !mem_we;
            if (mem_en && !mem_we) begin
                rsp_owner <= winner;
            end
            if (cpu_req && dbg_req && (conflict_cnt != CONFLICT_MAX)) begin
                conflict_cnt <= conflict_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations plus random
// traffic, all checked every cycle against a transaction-level reference model.
module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cpu_req = 1'b0, cpu_we = 1'b0;
    logic [4:0] cpu_addr = '0;
    logic [7:0] cpu_wdata = '0;
    logic       cpu_gnt, cpu_rvalid;
    logic [7:0] cpu_rdata;
    logic       dbg_req = 1'b0, dbg_we = 1'b0;
    logic [4:0] dbg_addr = '0;
    logic [7:0] dbg_wdata = '0;
    logic       dbg_gnt, dbg_rvalid;
    logic [7:0] dbg_rdata;
    logic       mem_en, mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = '0;
    logic [7:0] conflict_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- environment memory (one-cycle read latency) ----------------
    logic [7:0] mem [32] = '{default: 8'd0};
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + per-cycle compare ----------------
    // Model state: who won last, who owns the pending response, a shadow memory
    // and the count of contended cycles. exp_q holds the expected read response.
    logic [7:0] ref_mem [32] = '{default: 8'd0};
    int         m_last = 1;   // 0 = CPU, 1 = DBG
    int         m_cnt  = 0;
    int         m_pend = 0;   // 0 none, 1 CPU, 2 DBG
    logic [7:0] exp_q [$];

    always @(negedge clk) begin
        int w;
        logic [7:0] exp_d;
        if (!reset) begin
            chk("rst_cpu_gnt", cpu_gnt, 0);
            chk("rst_dbg_gnt", dbg_gnt, 0);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_cpu_rvalid", cpu_rvalid, 0);
            chk("rst_dbg_rvalid", dbg_rvalid, 0);
            chk("rst_conflict_cnt", conflict_cnt, 0);
            m_last = 1;
            m_cnt  = 0;
            m_pend = 0;
            exp_q.delete();
        end else begin
            chk("cpu_rvalid", cpu_rvalid, m_pend == 1);
            chk("dbg_rvalid", dbg_rvalid, m_pend == 2);
            if (m_pend != 0 && exp_q.size() > 0) begin
                exp_d = exp_q.pop_front();
                chk("rdata", (m_pend == 1) ? cpu_rdata : dbg_rdata, exp_d);
            end
            chk("conflict_cnt", conflict_cnt, m_cnt);

            if (cpu_req && dbg_req) w = (m_last == 1) ? 0 : 1;
            else if (cpu_req)       w = 0;
            else if (dbg_req)       w = 1;
            else                    w = -1;

            chk("cpu_gnt", cpu_gnt, w == 0);
            chk("dbg_gnt", dbg_gnt, w == 1);
            chk("mem_en", mem_en, w >= 0);
            if (w >= 0) begin
                chk("mem_we",    mem_we,    (w == 0) ? cpu_we    : dbg_we);
                chk("mem_addr",  mem_addr,  (w == 0) ? cpu_addr  : dbg_addr);
                chk("mem_wdata", mem_wdata, (w == 0) ? cpu_wdata : dbg_wdata);
            end

            // Advance the model across the coming rising edge.
            if (cpu_req && dbg_req && m_cnt < 255) m_cnt++;
            m_pend = 0;
            if (w >= 0) begin
                m_last = w;
                if ((w == 0) ? cpu_we : dbg_we) begin
                    ref_mem[(w == 0) ? cpu_addr : dbg_addr] = (w == 0) ? cpu_wdata : dbg_wdata;
                end else begin
                    m_pend = w + 1;
                    exp_q.push_back(ref_mem[(w == 0) ? cpu_addr : dbg_addr]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic r, input logic we, input int a, input int d);
        cpu_req = r; cpu_we = we; cpu_addr = 5'(a); cpu_wdata = 8'(d);
    endtask

    task automatic set_dbg(input logic r, input logic we, input int a, input int d);
        dbg_req = r; dbg_we = we; dbg_addr = 5'(a); dbg_wdata = 8'(d);
    endtask

    task automatic idle();
        set_cpu(0, 0, 0, 0);
        set_dbg(0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step();
        reset = 1'b0;
        idle();
        step();
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] fib [5];
        logic       tc, td;
        fib[0] = 8'd1; fib[1] = 8'd1; fib[2] = 8'd2; fib[3] = 8'd3; fib[4] = 8'd5;

        step();
        reset = 1'b1;

        // Write then read on the CPU port.
        step(); set_cpu(1, 1, 5, 13);
        @(negedge clk); chk("t1_wr_gnt", cpu_gnt, 1);
        step(); set_cpu(1, 0, 5, 0);
        @(negedge clk); chk("t1_rd_gnt", cpu_gnt, 1);
        step(); idle();
        @(negedge clk);
        chk("t1_cpu_rvalid", cpu_rvalid, 1);
        chk("t1_cpu_rdata", cpu_rdata, 13);
        chk("t1_dbg_rvalid", dbg_rvalid, 0);

        // Debug readout of a preloaded table.
        for (int i = 0; i < 5; i++) begin
            step(); set_dbg(1, 1, i, fib[i]);
        end
        for (int i = 0; i <= 5; i++) begin
            step();
            if (i < 5) set_dbg(1, 0, i, 0);
            else       idle();
            @(negedge clk);
            if (i < 5) chk("t2_dbg_gnt", dbg_gnt, 1);
            if (i > 0) begin
                chk("t2_dbg_rvalid", dbg_rvalid, 1);
                chk("t2_dbg_rdata", dbg_rdata, fib[i-1]);
            end
        end

        // Sustained contention alternates, starting with CPU.
        do_reset();
        set_cpu(1, 0, 1, 0);
        set_dbg(1, 0, 2, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_cpu_gnt", cpu_gnt, (i % 2) == 0);
            chk("t3_dbg_gnt", dbg_gnt, (i % 2) == 1);
            step();
        end
        idle();
        @(negedge clk); chk("t3_conflict_cnt", conflict_cnt, 4);

        // Counter saturation.
        do_reset();
        set_cpu(1, 0, 3, 0);
        set_dbg(1, 0, 4, 0);
        repeat (255) step();
        @(negedge clk); chk("t4_cnt_255", conflict_cnt, 255);
        repeat (45) step();
        @(negedge clk); chk("t4_cnt_hold", conflict_cnt, 255);
        step(); idle();

        // Reset the cycle after a debug read grant.
        do_reset();
        set_dbg(1, 0, 3, 0);
        @(negedge clk); chk("t5_dbg_gnt", dbg_gnt, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        idle();
        @(negedge clk);
        chk("t5_dbg_rvalid", dbg_rvalid, 0);
        chk("t5_cnt", conflict_cnt, 0);
        step();
        reset = 1'b1;
        set_cpu(1, 0, 0, 0);
        set_dbg(1, 0, 1, 0);
        @(negedge clk);
        chk("t5_first_cpu", cpu_gnt, 1);
        chk("t5_first_dbg", dbg_gnt, 0);
        step(); set_cpu(0, 0, 0, 0);
        step(); idle();

        // A write produces no response.
        step(); set_dbg(1, 1, 31, 8'hAA);
        @(negedge clk); chk("t6_dbg_gnt", dbg_gnt, 1);
        step(); set_dbg(0, 0, 0, 0); set_cpu(1, 0, 31, 0);
        @(negedge clk);
        chk("t6_no_cpu_rvalid", cpu_rvalid, 0);
        chk("t6_no_dbg_rvalid", dbg_rvalid, 0);
        step(); idle();
        @(negedge clk);
        chk("t6_cpu_rvalid", cpu_rvalid, 1);
        chk("t6_cpu_rdata", cpu_rdata, 8'hAA);

        // Random traffic obeying the hold-until-granted rule.
        do_reset();
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            tc = cpu_gnt;
            td = dbg_gnt;
            @(posedge clk); #1;
            if (!cpu_req || tc) begin
                set_cpu($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                        $urandom_range(0, 31), $urandom_range(0, 255));
            end
            if (!dbg_req || td) begin
                set_dbg($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                        $urandom_range(0, 31), $urandom_range(0, 255));
            end
        end
        step(); idle();
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
